tl_mem_slave: RTL and testbench

TileLink-UH memory slave sitting directly downstream of the Rocket tile master port in the subsystem testbench. It consumes channel A requests (Get, PutFullData, PutPartialData, single- or multi-beat), services them from an internal byte-maskable 64-bit-wide RAM, and returns responses on channel D. Channels B, C and E are not handled here; the tile-side wrapper ties them off (b_valid=0, c_ready=1, e_ready=1).

---
 rtl/tl_mem_pkg.sv | 39 +++
 rtl/tl_mem_ram.sv | 28 ++
 rtl/tl_mem_slave.sv | 179 +++++++++++++++++
 tb/tb_tl_mem_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tl_mem_pkg.sv
// Shared TileLink-UH types for the memory slave: channel opcodes, FSM states, field widths.
package tl_mem_pkg;

  localparam int OPCODE_W = 3;
  localparam int SIZE_W   = 4;
  localparam int SOURCE_W = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int MASK_W   = DATA_W / 8;

  typedef enum logic [OPCODE_W-1:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_op_e;

  typedef enum logic [OPCODE_W-1:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WBURST,
    ST_WRESP,
    ST_RBURST
  } state_e;

  // Beats on a 64-bit bus; sizes above 64 B never reach a burst so they collapse to 1.
  function automatic logic [3:0] beats_from_size(input logic [SIZE_W-1:0] size);
    case (size)
      4'd4:    return 4'd2;
      4'd5:    return 4'd4;
      4'd6:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/tl_mem_ram.sv
// Single-port-style RAM of 64-bit words with per-byte write enables and a registered read port.
// Read data appears one cycle after re and holds while re is low.
module tl_mem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wmask,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tl_mem_slave.sv
// TileLink-UH memory slave: services Get/PutFull/PutPartial bursts on channel A from a 64-bit RAM
// and answers on channel D. One request in flight; A is closed while a response is pending.
module tl_mem_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          MAX_SIZE    = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        io_a_ready,
  input  logic        io_a_valid,
  input  logic [2:0]  io_a_bits_opcode,
  input  logic [3:0]  io_a_bits_size,
  input  logic [1:0]  io_a_bits_source,
  input  logic [31:0] io_a_bits_address,
  input  logic [7:0]  io_a_bits_mask,
  input  logic [63:0] io_a_bits_data,
  input  logic        io_d_ready,
  output logic        io_d_valid,
  output logic [2:0]  io_d_bits_opcode,
  output logic [1:0]  io_d_bits_param,
  output logic [3:0]  io_d_bits_size,
  output logic [1:0]  io_d_bits_source,
  output logic [1:0]  io_d_bits_sink,
  output logic [2:0]  io_d_bits_addr_lo,
  output logic [63:0] io_d_bits_data,
  output logic        io_d_bits_error
);

  import tl_mem_pkg::*;

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state;
  logic [3:0]    k;
  logic [3:0]    beats_r;
  logic [AW-1:0] base_r;
  logic [63:0]   rdata;

  logic          a_fire, d_fire;
  logic          a_put, a_get, a_bad, a_oor;
  logic [3:0]    beats_a;
  logic [28:0]   widx_a;
  logic          we, re;
  logic [AW-1:0] waddr, raddr;

  always_comb begin
    a_fire  = io_a_valid && io_a_ready;
    d_fire  = io_d_valid && io_d_ready;
    a_put   = (io_a_bits_opcode == A_PUT_FULL) || (io_a_bits_opcode == A_PUT_PARTIAL);
    a_get   = (io_a_bits_opcode == A_GET);
    a_bad   = !(a_put || a_get) || (io_a_bits_size > 4'(MAX_SIZE));
    beats_a = beats_from_size(io_a_bits_size);
    widx_a  = 29'((io_a_bits_address - ADDR_BASE) >> 3);
    a_oor   = (io_a_bits_address < ADDR_BASE) ||
              ((32'(widx_a) + 32'(beats_a)) > 32'(DEPTH_WORDS));

    we    = 1'b0;
    re    = 1'b0;
    waddr = widx_a[AW-1:0];
    raddr = widx_a[AW-1:0];
    case (state)
      ST_IDLE: begin
        we = a_fire && a_put && !a_bad && !a_oor;
        re = a_fire && a_get && !a_bad;
      end
      ST_WBURST: begin
        we    = a_fire && !io_d_bits_error;
        waddr = base_r + AW'(k);
      end
      ST_RBURST: begin
        // Prefetch the next word on each D handshake so beats stream without bubbles.
        re    = d_fire;
        raddr = base_r + AW'(k) + AW'(1);
      end
      default: ;
    endcase
  end

  tl_mem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wmask (io_a_bits_mask),
    .wdata (io_a_bits_data),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign io_d_bits_param = '0;
  assign io_d_bits_sink  = '0;
  assign io_d_bits_data  = (state == ST_RBURST && !io_d_bits_error) ? rdata : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      k                 <= '0;
      beats_r           <= '0;
      base_r            <= '0;
      io_a_ready        <= 1'b0;
      io_d_valid        <= 1'b0;
      io_d_bits_opcode  <= '0;
      io_d_bits_size    <= '0;
      io_d_bits_source  <= '0;
      io_d_bits_addr_lo <= '0;
      io_d_bits_error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!io_a_ready) begin
            io_a_ready <= 1'b1;
          end else if (io_a_valid) begin
            io_d_bits_size    <= io_a_bits_size;
            io_d_bits_source  <= io_a_bits_source;
            io_d_bits_addr_lo <= io_a_bits_address[2:0];
            base_r            <= widx_a[AW-1:0];
            beats_r           <= beats_a;
            k                 <= '0;
            if (a_bad) begin
              state            <= ST_WRESP;
              io_a_ready       <= 1'b0;
              io_d_valid       <= 1'b1;
              io_d_bits_opcode <= D_ACCESS_ACK;
              io_d_bits_error  <= 1'b1;
            end else if (a_get) begin
              state            <= ST_RBURST;
              io_a_ready       <= 1'b0;
              io_d_valid       <= 1'b1;
              io_d_bits_opcode <= D_ACCESS_ACK_DATA;
              io_d_bits_error  <= a_oor;
            end else begin
              // The error flag doubles as the write-suppress flag for the rest of the burst.
              io_d_bits_opcode <= D_ACCESS_ACK;
              io_d_bits_error  <= a_oor;
              if (beats_a == 4'd1) begin
                state      <= ST_WRESP;
                io_a_ready <= 1'b0;
                io_d_valid <= 1'b1;
              end else begin
                state <= ST_WBURST;
                k     <= 4'd1;
              end
            end
          end
        end
        ST_WBURST: begin
          if (a_fire) begin
            k <= k + 4'd1;
            if (k == beats_r - 4'd1) begin
              state      <= ST_WRESP;
              io_a_ready <= 1'b0;
              io_d_valid <= 1'b1;
            end
          end
        end
        ST_WRESP: begin
          if (d_fire) begin
            state      <= ST_IDLE;
            io_d_valid <= 1'b0;
            io_a_ready <= 1'b1;
          end
        end
        ST_RBURST: begin
          if (d_fire) begin
            k <= k + 4'd1;
            if (k == beats_r - 4'd1) begin
              state      <= ST_IDLE;
              io_d_valid <= 1'b0;
              io_a_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_mem_slave.sv
// Directed bench for tl_mem_slave: puts, gets, stalled bursts, range errors, bad opcode, mid-burst reset.
module tb_tl_mem_slave;

  logic        clock;
  logic        reset_n;
  logic        io_a_ready;
  logic        io_a_valid;
  logic [2:0]  io_a_bits_opcode;
  logic [3:0]  io_a_bits_size;
  logic [1:0]  io_a_bits_source;
  logic [31:0] io_a_bits_address;
  logic [7:0]  io_a_bits_mask;
  logic [63:0] io_a_bits_data;
  logic        io_d_ready;
  logic        io_d_valid;
  logic [2:0]  io_d_bits_opcode;
  logic [1:0]  io_d_bits_param;
  logic [3:0]  io_d_bits_size;
  logic [1:0]  io_d_bits_source;
  logic [1:0]  io_d_bits_sink;
  logic [2:0]  io_d_bits_addr_lo;
  logic [63:0] io_d_bits_data;
  logic        io_d_bits_error;

  int n_checks = 0;
  int n_errors = 0;

  tl_mem_slave dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .io_a_ready        (io_a_ready),
    .io_a_valid        (io_a_valid),
    .io_a_bits_opcode  (io_a_bits_opcode),
    .io_a_bits_size    (io_a_bits_size),
    .io_a_bits_source  (io_a_bits_source),
    .io_a_bits_address (io_a_bits_address),
    .io_a_bits_mask    (io_a_bits_mask),
    .io_a_bits_data    (io_a_bits_data),
    .io_d_ready        (io_d_ready),
    .io_d_valid        (io_d_valid),
    .io_d_bits_opcode  (io_d_bits_opcode),
    .io_d_bits_param   (io_d_bits_param),
    .io_d_bits_size    (io_d_bits_size),
    .io_d_bits_source  (io_d_bits_source),
    .io_d_bits_sink    (io_d_bits_sink),
    .io_d_bits_addr_lo (io_d_bits_addr_lo),
    .io_d_bits_data    (io_d_bits_data),
    .io_d_bits_error   (io_d_bits_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed D metadata: opcode, size, source, addr_lo, error, param, sink.
  function automatic logic [16:0] d_meta_now();
    return {io_d_bits_opcode, io_d_bits_size, io_d_bits_source, io_d_bits_addr_lo,
            io_d_bits_error, io_d_bits_param, io_d_bits_sink};
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the A fire.
  task automatic a_send(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n = 0;
    io_a_valid        = 1'b1;
    io_a_bits_opcode  = op;
    io_a_bits_size    = sz;
    io_a_bits_source  = src;
    io_a_bits_address = addr;
    io_a_bits_mask    = mask;
    io_a_bits_data    = data;
    while (!io_a_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("a_ready_wait", 64'(io_a_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    io_a_valid = 1'b0;
  endtask

  task automatic d_beat(input string tag, input logic [2:0] op, input logic [3:0] sz,
                        input logic [1:0] src, input logic [2:0] lo, input logic [63:0] data,
                        input logic err);
    int n = 0;
    io_d_ready = 1'b1;
    while (!io_d_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_valid"}, 64'(io_d_valid), 64'd1);
    chk({tag, "_meta"}, 64'(d_meta_now()), 64'({op, sz, src, lo, err, 2'b00, 2'b00}));
    chk({tag, "_data"}, io_d_bits_data, data);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n           = 1'b0;
    io_a_valid        = 1'b0;
    io_a_bits_opcode  = '0;
    io_a_bits_size    = '0;
    io_a_bits_source  = '0;
    io_a_bits_address = '0;
    io_a_bits_mask    = '0;
    io_a_bits_data    = '0;
    io_d_ready        = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_a_ready", 64'(io_a_ready), 64'd0);
    chk("rst_d_valid", 64'(io_d_valid), 64'd0);
    chk("rst_d_meta", 64'(d_meta_now()), 64'd0);
    chk("rst_d_data", io_d_bits_data, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("a_ready_after_rst", 64'(io_a_ready), 64'd1);

    // Single-beat put then get of the same word
    a_send(3'd0, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
    chk("put_latency", 64'(io_d_valid), 64'd1);
    d_beat("put_ack", 3'd0, 4'd3, 2'd1, 3'd0, 64'd0, 1'b0);
    a_send(3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'd0);
    chk("get_latency", 64'(io_d_valid), 64'd1);
    d_beat("get1", 3'd1, 4'd3, 2'd2, 3'd0, 64'h1122_3344_5566_7788, 1'b0);
    chk("a_ready_after_get", 64'(io_a_ready), 64'd1);

    // Partial put over the low four lanes
    a_send(3'd1, 4'd3, 2'd0, 32'h8000_0010, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB);
    d_beat("pput_ack", 3'd0, 4'd3, 2'd0, 3'd0, 64'd0, 1'b0);
    a_send(3'd4, 4'd3, 2'd3, 32'h8000_0010, 8'hFF, 64'd0);
    d_beat("pget", 3'd1, 4'd3, 2'd3, 3'd0, 64'h1122_3344_AAAA_BBBB, 1'b0);
    a_send(3'd4, 4'd0, 2'd0, 32'h8000_0013, 8'h08, 64'd0);
    d_beat("get_lo3", 3'd1, 4'd0, 2'd0, 3'd3, 64'h1122_3344_AAAA_BBBB, 1'b0);

    // 8-beat put, then 8-beat get with D stalled every other cycle
    for (int i = 0; i < 8; i++)
      a_send(3'd0, 4'd6, 2'd3, 32'h8000_0040, 8'hFF, 64'(i));
    d_beat("wr8_ack", 3'd0, 4'd6, 2'd3, 3'd0, 64'd0, 1'b0);
    a_send(3'd4, 4'd6, 2'd1, 32'h8000_0040, 8'hFF, 64'd0);
    for (int i = 0; i < 8; i++) begin
      io_d_ready = 1'b0;
      @(negedge clock);
      chk("stall_valid", 64'(io_d_valid), 64'd1);
      chk("stall_meta", 64'(d_meta_now()), 64'({3'd1, 4'd6, 2'd1, 3'd0, 1'b0, 4'b0}));
      chk("stall_data", io_d_bits_data, 64'(i));
      d_beat("rd8", 3'd1, 4'd6, 2'd1, 3'd0, 64'(i), 1'b0);
    end
    chk("rd8_done", 64'(io_d_valid), 64'd0);

    // Range errors: below base, burst crossing the top, writes suppressed
    a_send(3'd0, 4'd3, 2'd0, 32'h8000_7FF8, 8'hFF, 64'hCAFE_F00D_1234_5678);
    d_beat("top_put", 3'd0, 4'd3, 2'd0, 3'd0, 64'd0, 1'b0);
    a_send(3'd4, 4'd3, 2'd2, 32'h7FFF_FFF8, 8'hFF, 64'd0);
    d_beat("low_get", 3'd1, 4'd3, 2'd2, 3'd0, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++)
      a_send(3'd0, 4'd6, 2'd1, 32'h8000_7FC8, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    d_beat("oor_put", 3'd0, 4'd6, 2'd1, 3'd0, 64'd0, 1'b1);
    a_send(3'd4, 4'd6, 2'd3, 32'h8000_7FF8, 8'hFF, 64'd0);
    for (int i = 0; i < 8; i++)
      d_beat("oor_get", 3'd1, 4'd6, 2'd3, 3'd0, 64'd0, 1'b1);
    chk("oor_get_done", 64'(io_d_valid), 64'd0);
    a_send(3'd4, 4'd3, 2'd0, 32'h8000_7FF8, 8'hFF, 64'd0);
    d_beat("top_intact", 3'd1, 4'd3, 2'd0, 3'd0, 64'hCAFE_F00D_1234_5678, 1'b0);

    // Unsupported opcode consumes one beat and errors
    a_send(3'd6, 4'd6, 2'd2, 32'h8000_0000, 8'hFF, 64'd0);
    d_beat("bad_op", 3'd0, 4'd6, 2'd2, 3'd0, 64'd0, 1'b1);
    chk("bad_op_a_ready", 64'(io_a_ready), 64'd1);

    // Reset asserted while beat 3 of a read is on D
    a_send(3'd4, 4'd6, 2'd0, 32'h8000_0040, 8'hFF, 64'd0);
    for (int i = 0; i < 3; i++)
      d_beat("pre_rst", 3'd1, 4'd6, 2'd0, 3'd0, 64'(i), 1'b0);
    chk("beat3_data", io_d_bits_data, 64'd3);
    reset_n    = 1'b0;
    io_d_ready = 1'b0;
    #1;
    chk("mid_rst_d_valid", 64'(io_d_valid), 64'd0);
    @(negedge clock);
    chk("mid_rst_d_valid_cyc", 64'(io_d_valid), 64'd0);
    chk("mid_rst_a_ready", 64'(io_a_ready), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_a_ready", 64'(io_a_ready), 64'd1);
    chk("post_rst_d_valid", 64'(io_d_valid), 64'd0);
    a_send(3'd4, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'd0);
    d_beat("post_rst_get", 3'd1, 4'd3, 2'd1, 3'd0, 64'h1122_3344_AAAA_BBBB, 1'b0);
    a_send(3'd4, 4'd4, 2'd2, 32'h8000_0050, 8'hFF, 64'd0);
    d_beat("post_rst_b0", 3'd1, 4'd4, 2'd2, 3'd0, 64'd2, 1'b0);
    d_beat("post_rst_b1", 3'd1, 4'd4, 2'd2, 3'd0, 64'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
